hs4_tx: RTL and testbench

Four-phase (return-to-zero) request/acknowledge transmitter that sends bundled-data words to a peer running on an unrelated clock or no clock at all. It is the outbound counterpart to the sync_high/sync_low input synchronizers: it drives `req_out` and `data_out` off-chip or across the domain boundary, and brings the peer's asynchronous `ack_in` back in through an internal two-flop synchronizer. It sits between a local producer, which uses a valid/ready handshake, and the asynchronous link.

---
 rtl/hs4_tx.sv | 134 +++++++++++++
 tb/tb_hs4_tx.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/hs4_tx.sv
// hs4_tx: four-phase return-to-zero bundled-data transmitter with a two-flop ack synchronizer.
// Define HS4_TX_ACK_TIMEOUT_EN to add the ack wait timeout, tx_err pulse and ERR state.
module hs4_tx #(
    parameter int DATA_WIDTH     = 8,
    parameter int SETUP_CYCLES   = 1,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  req_out,
    output logic [DATA_WIDTH-1:0] data_out,
    input  logic                  ack_in,
    output logic                  tx_done,
    output logic                  tx_err
);
    typedef enum logic [2:0] {
        IDLE, SETUP, REQ, REL
`ifdef HS4_TX_ACK_TIMEOUT_EN
        , ERR
`endif
    } state_t;

    localparam logic [3:0] SETUP_LAST = 4'(SETUP_CYCLES - 1);

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] data_d;
    logic                  req_d, done_d;
    logic                  ack_m, ack_s;

    assign tx_ready = (state_q == IDLE) && !ack_s;

`ifdef HS4_TX_ACK_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] wcnt_q, wcnt_d;
    logic        err_q, err_d;

    assign tx_err = err_q;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wcnt_q <= '0;
            err_q  <= 1'b0;
        end else begin
            wcnt_q <= wcnt_d;
            err_q  <= err_d;
        end
    end
`else
    assign tx_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            ack_m    <= 1'b0;
            ack_s    <= 1'b0;
            state_q  <= IDLE;
            cnt_q    <= '0;
            data_out <= '0;
            req_out  <= 1'b0;
            tx_done  <= 1'b0;
        end else begin
            ack_m    <= ack_in;
            ack_s    <= ack_m;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            data_out <= data_d;
            req_out  <= req_d;
            tx_done  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_out;
        req_d   = req_out;
        done_d  = 1'b0;
`ifdef HS4_TX_ACK_TIMEOUT_EN
        wcnt_d  = wcnt_q + 16'd1;
        err_d   = 1'b0;
`endif
        case (state_q)
            IDLE:
                if (tx_valid && tx_ready) begin
                    data_d  = tx_data;
                    cnt_d   = '0;
                    state_d = SETUP;
                end
            SETUP:
                if (cnt_q == SETUP_LAST) begin
                    req_d   = 1'b1;
                    state_d = REQ;
`ifdef HS4_TX_ACK_TIMEOUT_EN
                    wcnt_d  = '0;
`endif
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            REQ:
                // An ack arriving on the limit edge takes priority over the timeout.
                if (ack_s) begin
                    req_d   = 1'b0;
                    state_d = REL;
`ifdef HS4_TX_ACK_TIMEOUT_EN
                    wcnt_d  = '0;
                end else if (wcnt_q == TIMEOUT_LAST) begin
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = REL;
                    wcnt_d  = '0;
`endif
                end
            REL:
                if (!ack_s) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
`ifdef HS4_TX_ACK_TIMEOUT_EN
                end else if (wcnt_q == TIMEOUT_LAST) begin
                    err_d   = 1'b1;
                    state_d = ERR;
`endif
                end
`ifdef HS4_TX_ACK_TIMEOUT_EN
            ERR:
                if (!ack_s) state_d = IDLE;
`endif
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_hs4_tx.sv
// tb_hs4_tx: directed self-checking bench for hs4_tx (SETUP_CYCLES=1, TIMEOUT_CYCLES=10).
// Timeout scenario is checked when HS4_TX_ACK_TIMEOUT_EN is defined; otherwise tx_err must stay 0.
module tb_hs4_tx;
    logic       tb_clk = 1'b0;
    logic       n_rst;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       req_out;
    logic [7:0] data_out;
    logic       ack_in;
    logic       tx_done;
    logic       tx_err;

    int errors = 0;
    int checks = 0;
    int done_total = 0;
    int err_total = 0;

    hs4_tx #(.DATA_WIDTH(8), .SETUP_CYCLES(1), .TIMEOUT_CYCLES(10)) u_dut (
        .clk(tb_clk), .n_rst(n_rst), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .req_out(req_out), .data_out(data_out),
        .ack_in(ack_in), .tx_done(tx_done), .tx_err(tx_err)
    );

    always #5 tb_clk = ~tb_clk;

    always @(negedge tb_clk) begin
        if (tx_done === 1'b1) done_total++;
        if (tx_err === 1'b1) err_total++;
    end

    task automatic step();
        @(posedge tb_clk);
        #1;
    endtask

    task automatic test_reset();
        n_rst = 1'b0; tx_valid = 1'b0; tx_data = 8'h00; ack_in = 1'b0;
        repeat (2) @(posedge tb_clk);
        #1;
        checks++; if (req_out !== 1'b0) begin errors++; $display("FAIL reset_req got=%b exp=0", req_out); end
        checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data got=%h exp=00", data_out); end
        checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", tx_ready); end
        checks++; if (tx_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", tx_done); end
        checks++; if (tx_err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", tx_err); end
        n_rst = 1'b1;
        step();
    endtask

    task automatic test_single();
        tx_data = 8'hA5; tx_valid = 1'b1;
        checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL single_ready_pre got=%b exp=1", tx_ready); end
        step();
        tx_valid = 1'b0;
        checks++; if (data_out !== 8'hA5 || req_out !== 1'b0) begin errors++; $display("FAIL single_setup data=%h req=%b exp A5/0", data_out, req_out); end
        step();
        checks++; if (req_out !== 1'b1) begin errors++; $display("FAIL single_req_rise got=%b exp=1", req_out); end
        repeat (2) step();
        ack_in = 1'b1;
        step();
        checks++; if (req_out !== 1'b1) begin errors++; $display("FAIL single_req_e1 got=%b exp=1", req_out); end
        step();
        checks++; if (req_out !== 1'b1) begin errors++; $display("FAIL single_req_e2 got=%b exp=1", req_out); end
        step();
        checks++; if (req_out !== 1'b0) begin errors++; $display("FAIL single_req_fall got=%b exp=0", req_out); end
        repeat (2) step();
        ack_in = 1'b0;
        step();
        checks++; if (tx_done !== 1'b0) begin errors++; $display("FAIL single_done_e1 got=%b exp=0", tx_done); end
        step();
        checks++; if (tx_done !== 1'b0 || tx_ready !== 1'b0) begin errors++; $display("FAIL single_done_e2 done=%b ready=%b exp 0/0", tx_done, tx_ready); end
        step();
        checks++; if (tx_done !== 1'b1 || tx_ready !== 1'b1) begin errors++; $display("FAIL single_done_e3 done=%b ready=%b exp 1/1", tx_done, tx_ready); end
        step();
        checks++; if (tx_done !== 1'b0) begin errors++; $display("FAIL single_done_pulse got=%b exp=0", tx_done); end
    endtask

    task automatic test_ack_x();
        int d0 = done_total;
        int xs = 0;
        tx_data = 8'h3C; tx_valid = 1'b1;
        step();
        tx_valid = 1'b0;
        step();
        checks++; if (req_out !== 1'b1) begin errors++; $display("FAIL x_req_rise got=%b exp=1", req_out); end
        ack_in = 1'bx;
        for (int i = 0; i < 3; i++) begin
            step();
            if (req_out === 1'bx) xs++;
        end
        ack_in = 1'b0;
        #8 ack_in = 1'b1;
        #2 ack_in = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (req_out === 1'bx) xs++;
            ack_in = req_out;
            step();
        end
        ack_in = 1'b0;
        repeat (4) step();
        checks++; if (xs != 0) begin errors++; $display("FAIL x_req_unknown got=%0d exp=0", xs); end
        checks++; if (done_total - d0 != 1) begin errors++; $display("FAIL x_done_count got=%0d exp=1", done_total - d0); end
        checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL x_ready_end got=%b exp=1", tx_ready); end
    endtask

    task automatic test_reset_mid();
        int d0 = done_total;
        tx_data = 8'h77; tx_valid = 1'b1;
        step();
        tx_valid = 1'b0;
        step();
        ack_in = 1'b1;
        #2 n_rst = 1'b0;
        #1;
        checks++; if (req_out !== 1'b0) begin errors++; $display("FAIL rst_req_async got=%b exp=0", req_out); end
        repeat (2) step();
        n_rst = 1'b1;
        repeat (2) step();
        checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL rst_ready_stale got=%b exp=0", tx_ready); end
        repeat (3) step();
        ack_in = 1'b0;
        step();
        checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL rst_ready_e1 got=%b exp=0", tx_ready); end
        repeat (2) step();
        checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_e3 got=%b exp=1", tx_ready); end
        repeat (3) step();
        checks++; if (done_total != d0 || req_out !== 1'b0) begin errors++; $display("FAIL rst_no_done dones=%0d req=%b exp 0/0", done_total - d0, req_out); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] cap [2];
        int ncap = 0;
        int nd = 0;
        int e0 = err_total;
        logic prev_req = 1'b0;
        cap[0] = 8'h00; cap[1] = 8'h00;
        tx_data = 8'h01; tx_valid = 1'b1;
        for (int i = 0; i < 80 && nd < 2; i++) begin
            step();
            if (req_out && !prev_req && ncap < 2) begin cap[ncap] = data_out; ncap++; end
            prev_req = req_out;
            ack_in = req_out;
            if (tx_done === 1'b1) begin
                nd++;
                if (nd == 1) begin
                    tx_data = 8'h02;
                    step();
                    checks++; if (tx_ready !== 1'b0 || data_out !== 8'h02) begin errors++; $display("FAIL b2b_accept ready=%b data=%h exp 0/02", tx_ready, data_out); end
                    prev_req = req_out;
                    ack_in = req_out;
                end else begin
                    tx_valid = 1'b0;
                end
            end
        end
        tx_valid = 1'b0;
        ack_in = 1'b0;
        repeat (3) step();
        checks++; if (nd != 2) begin errors++; $display("FAIL b2b_done_count got=%0d exp=2", nd); end
        checks++; if (cap[0] !== 8'h01) begin errors++; $display("FAIL b2b_data0 got=%h exp=01", cap[0]); end
        checks++; if (cap[1] !== 8'h02) begin errors++; $display("FAIL b2b_data1 got=%h exp=02", cap[1]); end
        checks++; if (err_total != e0) begin errors++; $display("FAIL b2b_no_err got=%0d exp=0", err_total - e0); end
    endtask

    task automatic test_timeout();
        int k = 0;
        int e0 = err_total;
        tx_data = 8'h5A; tx_valid = 1'b1; ack_in = 1'b0;
        step();
        tx_valid = 1'b0;
        step();
        checks++; if (req_out !== 1'b1) begin errors++; $display("FAIL to_req_rise got=%b exp=1", req_out); end
`ifdef HS4_TX_ACK_TIMEOUT_EN
        while (req_out === 1'b1 && k < 40) begin step(); k++; end
        checks++; if (k != 10) begin errors++; $display("FAIL to_req_fall_cycles got=%0d exp=10", k); end
        checks++; if (tx_err !== 1'b1 || tx_done !== 1'b0) begin errors++; $display("FAIL to_err_pulse err=%b done=%b exp 1/0", tx_err, tx_done); end
        step();
        checks++; if (tx_err !== 1'b0 || tx_done !== 1'b1) begin errors++; $display("FAIL to_done_after err=%b done=%b exp 0/1", tx_err, tx_done); end
        repeat (3) step();
        checks++; if (err_total - e0 != 1) begin errors++; $display("FAIL to_err_count got=%0d exp=1", err_total - e0); end
`else
        repeat (20) begin step(); if (req_out !== 1'b1) k++; end
        checks++; if (k != 0) begin errors++; $display("FAIL nto_req_held drops=%0d exp=0", k); end
        checks++; if (err_total != e0) begin errors++; $display("FAIL nto_no_err got=%0d exp=0", err_total - e0); end
        ack_in = 1'b1;
        for (int i = 0; i < 10 && req_out; i++) step();
        ack_in = 1'b0;
        for (int i = 0; i < 10 && !tx_done; i++) step();
        checks++; if (tx_done !== 1'b1) begin errors++; $display("FAIL nto_late_done got=%b exp=1", tx_done); end
`endif
    endtask

    initial begin
        test_reset();
        test_single();
        test_ack_x();
        test_reset_mid();
        test_back_to_back();
        test_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
